// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, result packed {remainder, quotient}.
// Signed division is compiled in when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] rq_q, rq_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sgn_a, sgn_b;
    logic               divisor_zero;
    logic [WIDTH:0]     r_sh, trial;

    assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    assign sgn_a = signed_op & dividend[WIDTH-1];
    assign sgn_b = signed_op & divisor[WIDTH-1];
    assign mag_a = sgn_a ? -dividend : dividend;
    assign mag_b = sgn_b ? -divisor : divisor;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign sgn_a = 1'b0;
    assign sgn_b = 1'b0;
    assign mag_a = dividend;
    assign mag_b = divisor;
`endif

    // Shifted partial remainder needs WIDTH+1 bits so its top bit is not lost before the trial.
    assign r_sh  = rq_q[2*WIDTH-1:WIDTH-1];
    assign trial = r_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = divisor_zero ? StDone : StRun;
            StRun:   if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_comb begin
        rq_d     = rq_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvs_d = mag_b;
                    cnt_d = '0;
                    dbz_d = divisor_zero;
                    // Divide by zero skips the datapath: remainder is the raw dividend.
                    rq_d  = divisor_zero ? {dividend, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a};
`ifdef SEQ_DIVIDER_SIGNED_EN
                    neg_q_d = sgn_a ^ sgn_b;
                    neg_r_d = sgn_a;
`endif
                end
            end
            StRun: begin
                rq_d  = {(trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                         rq_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CntW'(1);
            end
            StFix: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                rq_d = {(neg_r_q ? -rq_q[2*WIDTH-1:WIDTH] : rq_q[2*WIDTH-1:WIDTH]),
                        (neg_q_q ? -rq_q[WIDTH-1:0] : rq_q[WIDTH-1:0])};
`endif
            end
            StDone: begin
                result_d = rq_q;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            rq_q     <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
`endif
        end else begin
            rq_q     <= rq_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
`endif
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=32; signed vectors follow SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

    localparam int unsigned W     = 32;
    localparam int          LIMIT = 200;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [2*W-1:0] result;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic sgn, logic [31:0] a, logic [31:0] b,
                                logic [31:0] q, logic [31:0] r, logic dbz, int lat);
        vec_t v;
        v.name = name; v.sgn = sgn; v.a = a; v.b = b;
        v.q = q; v.r = r; v.dbz = dbz; v.lat = lat;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic launch(logic s, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(string name, logic [31:0] q, logic [31:0] r, logic dbz);
        chk({name, ".quot"}, 64'(result[W-1:0]), 64'(q));
        chk({name, ".rem"}, 64'(result[2*W-1:W]), 64'(r));
        chk({name, ".dbz"}, 64'(div_by_zero), 64'(dbz));
    endtask

    initial begin
        int lat;
        int pre;

        vecs.push_back(mk("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34));
        vecs.push_back(mk("dbz",       1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1));
        vecs.push_back(mk("umax_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34));
        vecs.push_back(mk("u5_9",      1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34));
        vecs.push_back(mk("umax_max",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 34));
        vecs.push_back(mk("umin_max",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34));
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back(mk("s-7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34));
        vecs.push_back(mk("s7_-2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34));
        vecs.push_back(mk("s-7_-2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 34));
        vecs.push_back(mk("smin_-1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34));
        vecs.push_back(mk("s_dbz",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1));
`else
        vecs.push_back(mk("ign-7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 34));
        vecs.push_back(mk("ign7_-2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,          1'b0, 34));
        vecs.push_back(mk("ignmin_-1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34));
`endif

        clr       = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.dbz", 64'(div_by_zero), 64'd0);
        chk("reset.result", result, 64'd0);
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
            chk({vecs[i].name, ".busy0"}, 64'(busy), 64'd1);
            wait_done(lat);
            chk({vecs[i].name, ".lat"}, 64'(lat), 64'(vecs[i].lat));
            chk({vecs[i].name, ".busy_at_done"}, 64'(busy), 64'd0);
            check_result(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].dbz);
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".done_pulse"}, 64'(done), 64'd0);
        end

        // Start while busy must be ignored; start right after done must be accepted.
        launch(1'b0, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pre   = 5;
        wait_done(lat);
        chk("hs.lat", 64'(lat + pre), 64'd34);
        check_result("hs.orig", 32'd14, 32'd2, 1'b0);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hs.b2b_busy", 64'(busy), 64'd1);
        chk("hs.hold_during_busy", result, {32'd2, 32'd14});
        wait_done(lat);
        chk("hs.b2b_lat", 64'(lat), 64'd34);
        check_result("hs.b2b", 32'd3, 32'd0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hs.hold", result, {32'd0, 32'd3});
        chk("hs.idle_done", 64'(done), 64'd0);

        // Abort mid-operation.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.result", result, 64'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("abort.no_done", 64'(done), 64'd0);
        end
        launch(1'b0, 32'd9, 32'd3);
        wait_done(lat);
        chk("after_abort.lat", 64'(lat), 64'd34);
        check_result("after_abort", 32'd3, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider for the CPU datapath, with a start/done handshake. It computes quotient and remainder one bit per clock. Results are packed as {remainder, quotient} for direct load into the HI/LO register pair. Optional two's-complement signed division is compiled in by macro, and a divide-by-zero flag is provided.

## Interface
- WIDTH, 32, operand width in bits; legal values are 4 to 64.
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 selects signed division; sampled with start.
- dividend  input  WIDTH  dividend; sampled with start.
- divisor  input  WIDTH  divisor; sampled with start.
- busy  output  1  high while a request is in flight.
- done  output  1  one-cycle pulse when the result is valid.
- div_by_zero  output  1  valid with done; held until the next accepted start.
- result  output  2*WIDTH  [2*WIDTH-1:WIDTH] is the remainder, [WIDTH-1:0] is the quotient.

## Operation
- State machine: IDLE, RUN, FIX, DONE.
- IDLE + start=1 → RUN.
  - Latch the operands and clear the iteration counter.
  - Signed requests latch operand magnitudes plus the two sign bits.
- IDLE + start=1 + divisor=0 → DONE directly, with div_by_zero=1.
  - quotient = all ones.
  - remainder = dividend unchanged.
- RUN performs one restoring step per cycle on a {R, Q} register of width 2*WIDTH:
  - shift left by 1;
  - trial = R − divisor, computed in WIDTH+1 bits;
  - if trial is negative: restore R, Q[0]=0; otherwise R=trial, Q[0]=1.
- After WIDTH steps → FIX.
- FIX applies sign correction:
  - quotient is negated if the dividend sign XOR the divisor sign is 1;
  - remainder is negated if the dividend sign is 1;
  - this gives truncation toward zero, with the remainder taking the dividend's sign.
  - Unsigned requests pass through unchanged.
- Signed MIN ÷ −1 gives quotient = MIN and remainder = 0, by natural wrap. No flag is raised.
- FIX → DONE; DONE → IDLE unconditionally.
- result and div_by_zero hold their values in IDLE until the next accepted start.
- start while busy=1 is ignored; the operands are not resampled.
- clr=0 in any state → IDLE on the next edge, aborting any operation in progress. No done pulse is issued.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, result=0, state IDLE.
- Edge numbering: start accepted at edge 0 → busy=1 after edge 0.
  - Iterations occur on edges 1..WIDTH.
  - FIX occurs at edge WIDTH+1.
  - done=1 and result valid after edge WIDTH+2.
  - busy=0 in that same cycle.
- Latency from start to done is WIDTH+2 cycles: 34 for WIDTH=32.
- Divide by zero: done=1 after edge 1, a latency of 1 cycle.
- A new start is accepted in the cycle after the done pulse, so back-to-back throughput is one result per WIDTH+3 cycles.
- done is high for exactly one cycle. busy and done are never high together.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined:
  - signed_op is honoured;
  - the sign-magnitude latch and FIX negation logic are present.
- Not defined:
  - signed_op is ignored and all operations are unsigned;
  - FIX is a pass-through state, so latency is unchanged.

## Test plan
- Unsigned, WIDTH=32: 100 ÷ 7 → quotient 14, remainder 2; done exactly 34 cycles after start; div_by_zero=0.
- Signed (macro on): −7 ÷ 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 ÷ −2 → quotient −3, remainder 1.
- Divide by zero: 0x1234 ÷ 0 → done 1 cycle after start; div_by_zero=1; quotient 0xFFFFFFFF; remainder 0x1234.
- Signed overflow: 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0. Also unsigned 0xFFFFFFFF ÷ 1 → quotient 0xFFFFFFFF, remainder 0.
- Handshake: re-assert start with new operands while busy → ignored, and the original result is returned. Then start in the cycle after done → accepted.
- Reset: clr=0 at cycle 10 of an operation → next cycle busy=0, done=0, result=0. A subsequent 9 ÷ 3 completes normally with quotient 3, remainder 0.
